// File: rtl/share_state_buffer.sv
// share_state_buffer
//   Collects a 128-bit masked state one word index at a time (all shares
//   of that word per beat), presents it to the round logic, captures the
//   round result and streams it back out one word index per handshake.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   pdi_data     input word, all shares; share i in [BUSW*i +: BUSW]
//   pdi_valid    pdi_data valid
//   pdi_ready    buffer accepts an input beat (LOAD)
//   statein      assembled word-interleaved state
//   state_valid  statein complete and stable (FULL)
//   tbc_done     one-cycle pulse, nextstate valid
//   nextstate    word-interleaved round result
//   pdo_data     output word, all shares, same packing as pdi_data
//   pdo_valid    pdo_data valid (UNLOAD)
//   pdo_ready    consumer accepts pdo_data
//
// state  | meaning
// LOAD   | accepting input beats into slot cnt
// FULL   | state complete, waiting for tbc_done
// UNLOAD | streaming slot cnt out on each handshake
module share_state_buffer #(
  parameter int BUSW        = 32,
  parameter int STATESHARES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUSW*STATESHARES-1:0] pdi_data,
  input  logic                       pdi_valid,
  output logic                       pdi_ready,
  output logic [128*STATESHARES-1:0] statein,
  output logic                       state_valid,
  input  logic                       tbc_done,
  input  logic [128*STATESHARES-1:0] nextstate,
  output logic [BUSW*STATESHARES-1:0] pdo_data,
  output logic                       pdo_valid,
  input  logic                       pdo_ready
);

  localparam int W  = 128 / BUSW;
  localparam int WW = BUSW * STATESHARES;
  localparam int CW = $clog2(W) + 1;
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {LOAD, FULL, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   words [W];
  logic            wr_en;
  logic            load_all;
  logic            last;
  logic [IW-1:0]   idx;

  assign idx  = cnt_q[IW-1:0];
  assign last = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pdi_ready   = 1'b0;
    state_valid = 1'b0;
    pdo_valid   = 1'b0;
    wr_en       = 1'b0;
    load_all    = 1'b0;
    case (state_q)
      LOAD: begin
        pdi_ready = 1'b1;
        if (pdi_valid) begin
          wr_en = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        state_valid = 1'b1;
        if (tbc_done) begin
          load_all = 1'b1;
          state_d  = UNLOAD;
        end
      end
      UNLOAD: begin
        pdo_valid = 1'b1;
        if (pdo_ready) begin
          if (last) begin
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // wr_en and load_all are decoded from mutually exclusive states.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < W; j++) words[j] <= '0;
    end else if (wr_en) begin
      words[idx] <= pdi_data;
    end else if (load_all) begin
      for (int j = 0; j < W; j++) words[j] <= nextstate[j*WW +: WW];
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_flat
    assign statein[j*WW +: WW] = words[j];
  end

  // Mux driven only by registers: no input-to-pdo_data path.
  assign pdo_data = words[idx];

endmodule

// File: tb/tb_share_state_buffer.sv
module tb_share_state_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  pdi_data;
  logic         pdi_valid;
  logic         pdi_ready;
  logic [255:0] statein;
  logic         state_valid;
  logic         tbc_done;
  logic [255:0] nextstate;
  logic [63:0]  pdo_data;
  logic         pdo_valid;
  logic         pdo_ready;

  share_state_buffer #(.BUSW(32), .STATESHARES(2)) dut (
    .clk(clk), .rst(rst),
    .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
    .statein(statein), .state_valid(state_valid),
    .tbc_done(tbc_done), .nextstate(nextstate),
    .pdo_data(pdo_data), .pdo_valid(pdo_valid), .pdo_ready(pdo_ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference: an image of the four 64-bit slots, the list of beats taken
  // so far in the current load, and a queue of words still to be sent.
  typedef enum {M_LOAD, M_FULL, M_UNLOAD} mphase_t;
  mphase_t     ph;
  logic [63:0] m_img [4];
  logic [63:0] in_q  [$];
  logic [63:0] out_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [255:0] img_flat();
    return {m_img[3], m_img[2], m_img[1], m_img[0]};
  endfunction

  task automatic model_step();
    if (rst) begin
      foreach (m_img[j]) m_img[j] = '0;
      in_q.delete();
      out_q.delete();
      ph = M_LOAD;
    end else begin
      case (ph)
        M_LOAD: if (pdi_valid) begin
          m_img[in_q.size()] = pdi_data;
          in_q.push_back(pdi_data);
          if (in_q.size() == 4) begin
            in_q.delete();
            ph = M_FULL;
          end
        end
        M_FULL: if (tbc_done) begin
          for (int j = 0; j < 4; j++) begin
            m_img[j] = nextstate[64*j +: 64];
            out_q.push_back(nextstate[64*j +: 64]);
          end
          ph = M_UNLOAD;
        end
        M_UNLOAD: if (pdo_ready) begin
          void'(out_q.pop_front());
          if (out_q.size() == 0) ph = M_LOAD;
        end
        default: ;
      endcase
    end
  endtask

  // One clock: advance model with the applied inputs, then compare.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("pdi_ready",   256'(pdi_ready),   256'(ph == M_LOAD));
    chk("state_valid", 256'(state_valid), 256'(ph == M_FULL));
    chk("pdo_valid",   256'(pdo_valid),   256'(ph == M_UNLOAD));
    chk("statein",     statein,           img_flat());
    if (ph == M_UNLOAD) chk("pdo_data", 256'(pdo_data), 256'(out_q[0]));
  endtask

  task automatic idle();
    rst = 0; pdi_valid = 0; tbc_done = 0; pdo_ready = 0;
  endtask

  task automatic load4(input int k0);
    for (int k = k0; k < k0 + 4; k++) begin
      pdi_valid = 1;
      pdi_data  = {32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k)};
      cyc();
    end
    pdi_valid = 0;
  endtask

  logic [255:0] snap;
  int hs;

  initial begin
    idle();
    pdi_data  = '0;
    nextstate = '0;
    ph = M_LOAD;

    // Reset
    rst = 1; cyc(); cyc();
    rst = 0;
    chk("rst_pdo_data", 256'(pdo_data), 256'(0));
    chk("rst_statein",  statein, 256'(0));

    // Scenario 1: four back-to-back beats
    load4(0);
    chk("s1_state_valid", 256'(state_valid), 256'(1));
    for (int k = 0; k < 4; k++)
      chk("s1_word", statein[64*k +: 64],
          256'({32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k)}));

    // Scenario 2: pdi_valid ignored in FULL
    snap = img_flat();
    pdi_valid = 1; pdi_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s2_pdi_ready", 256'(pdi_ready), 256'(0));
    end
    pdi_valid = 0;
    chk("s2_statein", statein, snap);

    // Scenario 3: result streamed out with pdo_ready held high
    for (int j = 0; j < 4; j++)
      nextstate[64*j +: 64] = {2{32'hC0DE_0000 + 32'(j)}};
    pdo_ready = 1; tbc_done = 1; cyc();
    tbc_done = 0;
    for (int j = 0; j < 4; j++) begin
      chk("s3_pdo_data", 256'(pdo_data), 256'({2{32'hC0DE_0000 + 32'(j)}}));
      cyc();
    end
    chk("s3_pdi_ready", 256'(pdi_ready), 256'(1));
    pdo_ready = 0;

    // Scenario 4: random state, pdo_ready pattern 0,1,0,0,1,...
    for (int k = 0; k < 4; k++) begin
      pdi_valid = 1; pdi_data = {$urandom, $urandom}; cyc();
    end
    pdi_valid = 0;
    for (int j = 0; j < 8; j++) nextstate[32*j +: 32] = $urandom;
    tbc_done = 1; cyc(); tbc_done = 0;
    hs = 0;
    for (int i = 0; i < 40 && pdo_valid; i++) begin
      pdo_ready = (i % 3 != 0 && i % 3 != 2) || (i % 5 == 4);
      if (pdo_valid && pdo_ready) hs++;
      cyc();
    end
    pdo_ready = 0;
    chk("s4_handshakes", 256'(hs), 256'(4));
    chk("s4_back_to_load", 256'(pdi_ready), 256'(1));

    // Scenario 5: reset mid-load, then fresh load k=4..7
    for (int k = 0; k < 2; k++) begin
      pdi_valid = 1; pdi_data = {$urandom, $urandom}; cyc();
    end
    pdi_valid = 0;
    rst = 1; tbc_done = 1; pdo_ready = 1; cyc();
    idle();
    chk("s5_rst_statein", statein, 256'(0));
    load4(4);
    chk("s5_state_valid", 256'(state_valid), 256'(1));
    for (int k = 4; k < 8; k++)
      chk("s5_word", statein[64*(k-4) +: 64],
          256'({32'h1111_0000 + 32'(k), 32'hAAAA_0000 + 32'(k)}));

    // Scenario 6: tbc_done during LOAD is ignored
    rst = 1; cyc(); rst = 0;
    pdo_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tbc_done = 1; cyc();
      chk("s6_pdo_valid", 256'(pdo_valid), 256'(0));
    end
    tbc_done = 0;
    load4(0);
    chk("s6_state_valid", 256'(state_valid), 256'(1));
    pdo_ready = 0;

    // Random traffic against the reference
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      pdi_valid = $urandom_range(0, 1);
      pdi_data  = {$urandom, $urandom};
      tbc_done  = ($urandom_range(0, 3) == 0);
      pdo_ready = $urandom_range(0, 1);
      for (int j = 0; j < 8; j++) nextstate[32*j +: 32] = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
